// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - small output buffer of fetched {pc, instr} entries
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, instruction memory request FSM and decode-facing buffer
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    logic [31:0]   req_pc;
    logic          discard;
    logic          discard_next;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          space;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign push       = (state == ST_WAIT) && imem_rvalid && !discard && !redirect_valid;
    assign push_entry = '{pc: req_pc, instr: imem_rdata};

    // Occupancy after this edge; nothing is outstanding whenever a new request is considered.
    assign count_next = redirect_valid ? '0
                      : count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    assign space      = count_next < CW'(FIFO_DEPTH);

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = req_pc;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;

        // A stale request (discard set) must not advance pc, which already holds the target.
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if ((state == ST_REQ) && imem_gnt && !discard) begin
            pc_next = pc + 32'd4;
        end

        case (state)
            ST_IDLE: if (space) state_next = ST_REQ;
            ST_REQ:  if (imem_gnt) state_next = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_next = space ? ST_REQ : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (redirect_valid) begin
            if (state == ST_REQ) begin
                discard_next = 1'b1;
            end else if (state == ST_WAIT) begin
                discard_next = !imem_rvalid;
            end
        end else if ((state == ST_WAIT) && imem_rvalid) begin
            discard_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            discard     <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            discard     <= discard_next;
            fetch_error <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            // The address is frozen for the whole request so it stays stable until granted.
            if ((state_next == ST_REQ) && (state != ST_REQ)) begin
                req_pc <= pc_next;
            end
        end
    end

    instruction_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

endmodule
